// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote sampling, false-start rejection,
// framing/parity/overrun flags and a held-valid/ack handshake. Optional parity: UART_RX_PARITY_EN.
module uart_rx_os #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUDRATE   = 9600,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned S_LO  = OVERSAMPLE / 2 - 1;
  localparam int unsigned S_MID = OVERSAMPLE / 2;
  localparam int unsigned S_HI  = OVERSAMPLE / 2 + 1;

  if (DIV < 1 || DATA_WIDTH < 5 || DATA_WIDTH > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_os: illegal parameter set");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic                  sync1, line_s;
  logic [DIV_W-1:0]      div_cnt;
  logic [OS_W-1:0]       os_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  stop_cnt;
  logic                  armed;
  logic                  v0, v1;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  fe_acc;
  logic                  pe_acc;
  logic                  done;
  logic                  tick, sample_tick, maj;

  assign tick        = (div_cnt == DIV_W'(DIV - 1));
  assign sample_tick = tick && (os_cnt == OS_W'(S_HI));
  assign maj         = (v0 & v1) | (v0 & line_s) | (v1 & line_s);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync1      <= 1'b1;
      line_s     <= 1'b1;
      div_cnt    <= '0;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      armed      <= 1'b0;
      v0         <= 1'b1;
      v1         <= 1'b1;
      shreg      <= '0;
      fe_acc     <= 1'b0;
      pe_acc     <= 1'b0;
      done       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync1  <= line;
      line_s <= sync1;
      done   <= 1'b0;

      // Free-running tick and in-bit phase; realigned on start-bit detect below
      if (tick) begin
        div_cnt <= '0;
        os_cnt  <= (os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt + OS_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (tick && os_cnt == OS_W'(S_LO))  v0 <= line_s;
      if (tick && os_cnt == OS_W'(S_MID)) v1 <= line_s;

      case (state)
        IDLE: begin
          if (line_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state   <= START;
            busy    <= 1'b1;
            armed   <= 1'b0;
            div_cnt <= '0;
            os_cnt  <= '0;
          end
        end
        START: begin
          if (sample_tick) begin
            if (maj) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
        end
        DATA: begin
          if (sample_tick) begin
            shreg   <= {maj, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
              stop_cnt <= 1'b0;
              fe_acc   <= 1'b0;
              pe_acc   <= 1'b0;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample_tick) begin
            pe_acc <= (^shreg) ^ maj ^ 1'(PARITY_ODD);
            state  <= STOP;
          end
        end
`endif
        STOP: begin
          // Leave at the sample tick, not the bit end, so a following start edge is seen
          if (sample_tick) begin
            fe_acc   <= fe_acc | ~maj;
            stop_cnt <= 1'b1;
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Output handshake: load when free or acked this cycle, otherwise drop and flag overrun
      if (done && (!rx_valid || rx_ack)) begin
        rx_data   <= shreg;
        frame_err <= fe_acc;
`ifdef UART_RX_PARITY_EN
        parity_err <= pe_acc;
`else
        parity_err <= 1'b0;
`endif
        rx_valid  <= 1'b1;
        if (rx_ack) overrun <= 1'b0;
      end else if (done) begin
        overrun <= 1'b1;
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed scenarios plus randomized frames
// checked against a transaction-level model of the held-word handshake.
module tb_uart_rx_os;

  localparam int unsigned CLK_FREQ = 50000000;
  localparam int unsigned BAUD     = 115200;
  localparam int unsigned OS       = 16;
  localparam int unsigned PAR_ODD  = 0;
  localparam int unsigned BIT_CLKS = (CLK_FREQ / (BAUD * OS)) * OS;
`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       line;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ack, frame_err, parity_err, overrun, busy;

  uart_rx_os #(
    .CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD), .DATA_WIDTH(8),
    .OVERSAMPLE(OS), .STOP_BITS(1), .PARITY_ODD(PAR_ODD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .line(line), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ack(rx_ack), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected consumer-visible state
  logic       m_valid, m_fe, m_pe, m_ovr;
  logic [7:0] m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic fe, input logic pe);
    if (!m_valid) begin
      m_valid = 1'b1; m_data = d; m_fe = fe; m_pe = pe;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},  32'(rx_valid),   32'(m_valid));
    check({tag, ".data"},   32'(rx_data),    32'(m_data));
    check({tag, ".ferr"},   32'(frame_err),  32'(m_fe));
    check({tag, ".perr"},   32'(parity_err), 32'(m_pe));
    check({tag, ".ovr"},    32'(overrun),    32'(m_ovr));
    check({tag, ".busy"},   32'(busy),       32'(0));
  endtask

  task automatic send_bit(input logic b);
    line = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // start + 8 data (LSB first) + optional parity + one stop bit, then idle high
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_flip);
    logic p;
    p = (^d) ^ 1'(PAR_ODD) ^ par_flip;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (HAS_PAR) send_bit(p);
    send_bit(stop_ok);
    line = 1'b1;
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       stop_ok, flip, ack;

    rst_n = 1'b0; line = 1'b1; rx_ack = 1'b0;
    model_reset();
    idle_clks(5);
    rst_n = 1'b1;
    idle_clks(5);
    check_all("reset");

    // Basic 8N1 frame and ack
    send_frame(8'hA5, 1'b1, 1'b0);
    idle_clks(4);
    model_frame(8'hA5, 1'b0, 1'b0);
    check_all("a5");
    do_ack();
    check_all("a5_ack");

    // 0.2-bit glitch must be rejected as a false start
    line = 1'b0;
    idle_clks(BIT_CLKS / 5);
    line = 1'b1;
    idle_clks(2 * BIT_CLKS);
    check_all("glitch");

    // Stop bit low -> framing error, word still delivered
    send_frame(8'h3C, 1'b0, 1'b0);
    idle_clks(4);
    model_frame(8'h3C, 1'b1, 1'b0);
    check_all("ferr");
    do_ack();
    check_all("ferr_ack");
    idle_clks(BIT_CLKS);

    // Back-to-back frames without ack -> second dropped, overrun set
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle_clks(4);
    model_frame(8'h11, 1'b0, 1'b0);
    model_frame(8'h22, 1'b0, 1'b0);
    check_all("ovr");
    do_ack();
    check_all("ovr_ack");

    if (HAS_PAR) begin
      send_frame(8'h07, 1'b1, 1'b1);
      idle_clks(4);
      model_frame(8'h07, 1'b0, 1'b1);
      check_all("perr");
      do_ack();
      check_all("perr_ack");
    end

    // Leave a word held, then reset in the middle of bit 4 of a new frame
    send_frame(8'hC3, 1'b1, 1'b0);
    idle_clks(4);
    model_frame(8'hC3, 1'b0, 1'b0);
    check_all("pre_rst");
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
    line = 1'b0;
    idle_clks(BIT_CLKS / 2);
    check("mid_rst.busy", 32'(busy), 32'(1));
    line  = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_all("mid_rst");
    idle_clks(2 * BIT_CLKS);
    check_all("post_rst_idle");
    send_frame(8'h5A, 1'b1, 1'b0);
    idle_clks(4);
    model_frame(8'h5A, 1'b0, 1'b0);
    check_all("5a");
    do_ack();
    check_all("5a_ack");

    // Randomized frames, stop errors, parity flips and ack patterns
    for (int n = 0; n < 24; n++) begin
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      flip    = HAS_PAR && ($urandom_range(0, 3) == 0);
      ack     = ($urandom_range(0, 9) < 6);
      send_frame(d, stop_ok, flip);
      idle_clks(4);
      model_frame(d, ~stop_ok, flip);
      check_all($sformatf("rnd%0d", n));
      if (ack) begin
        do_ack();
        check_all($sformatf("rnd%0d_ack", n));
      end
      idle_clks((stop_ok ? 0 : BIT_CLKS) + int'($urandom_range(0, 200)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
